// File: rtl/uart_color_cmd.sv
// uart_color_cmd: parses 6-byte color command frames (SOF, SEL, R, G, B, CHK)
// from the UART receiver and updates the two registered LCD colors.
// Bad selects, bad checksums and inter-byte timeouts are reported on
// frame_err / err_code.
module uart_color_cmd #(
   parameter int unsigned CLK_HZ         = 27_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 2_700_000,
   parameter logic [7:0]  SOF_BYTE       = 8'hAA,
   parameter logic [23:0] P1_RESET       = 24'hFF0000,
   parameter logic [23:0] P2_RESET       = 24'h0000FF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data_rx,
   input  logic        data_ready,
   output logic [23:0] color_p1,
   output logic [23:0] color_p2,
   output logic        color_update,
   output logic        update_sel,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic        busy
);

   // CLK_HZ only documents the clock the timeout was sized for; this empty
   // block keeps the parameter referenced without adding logic.
   if (CLK_HZ == 0) begin : g_clk_hz_unset
   end

   localparam int unsigned   CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_SEL     = 2'd1;
   localparam logic [1:0] ERR_CHK     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      GET_SEL,
      GET_R,
      GET_G,
      GET_B,
      GET_CHK
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       sel_q, r_q, g_q, b_q;
   logic [23:0]      p1_q, p2_q;
   logic             color_update_q, update_sel_q, frame_err_q;
   logic [1:0]       err_code_q;

   logic [7:0]       chk_d;
   logic             timeout_d;

   // Checksum the CHK byte must equal, and the idle-limit hit inside a frame.
   assign chk_d     = sel_q ^ r_q ^ g_q ^ b_q;
   assign timeout_d = (state_q != IDLE) && (cnt_q == CNT_LAST);

   // Frame FSM, inter-byte timeout counter and all registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: every register here uses <= so all of them update from the same
      // pre-edge values; a blocking = would let later lines see new values.
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         sel_q          <= '0;
         r_q            <= '0;
         g_q            <= '0;
         b_q            <= '0;
         p1_q           <= P1_RESET;
         p2_q           <= P2_RESET;
         color_update_q <= 1'b0;
         update_sel_q   <= 1'b0;
         frame_err_q    <= 1'b0;
         err_code_q     <= 2'd0;
      end else begin
         color_update_q <= 1'b0;
         frame_err_q    <= 1'b0;

         // Counter only runs mid-frame; any consumed byte restarts it.
         if (state_q == IDLE || data_ready)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + 1'b1;

         if (data_ready) begin
            // A byte on the limit cycle wins over the timeout.
            case (state_q)
               IDLE: begin
                  if (data_rx == SOF_BYTE)
                     state_q <= GET_SEL;
               end
               GET_SEL: begin
                  if (data_rx == 8'h01 || data_rx == 8'h02) begin
                     sel_q   <= data_rx;
                     state_q <= GET_R;
                  end else begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= ERR_SEL;
                     state_q     <= IDLE;
                  end
               end
               GET_R: begin
                  r_q     <= data_rx;
                  state_q <= GET_G;
               end
               GET_G: begin
                  g_q     <= data_rx;
                  state_q <= GET_B;
               end
               GET_B: begin
                  b_q     <= data_rx;
                  state_q <= GET_CHK;
               end
               GET_CHK: begin
                  if (data_rx == chk_d) begin
                     if (sel_q == 8'h02)
                        p2_q <= {r_q, g_q, b_q};
                     else
                        p1_q <= {r_q, g_q, b_q};
                     update_sel_q   <= (sel_q == 8'h02);
                     color_update_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= ERR_CHK;
                  end
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end else if (timeout_d) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
            state_q     <= IDLE;
            cnt_q       <= '0;
         end
      end
   end

   assign color_p1     = p1_q;
   assign color_p2     = p2_q;
   assign color_update = color_update_q;
   assign update_sel   = update_sel_q;
   assign frame_err    = frame_err_q;
   assign err_code     = err_code_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_color_cmd.sv
// Directed bench for uart_color_cmd: valid frames, ignored noise, bad select,
// bad checksum, inter-byte timeout and its race, mid-frame reset and
// back-to-back frames. Expected values are hand-computed constants.
module tb_uart_color_cmd;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  data_rx;
   logic        data_ready;
   logic [23:0] color_p1, color_p2;
   logic        color_update, update_sel, frame_err, busy;
   logic [1:0]  err_code;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_color_cmd #(
      .CLK_HZ        (27_000_000),
      .TIMEOUT_CYCLES(20),
      .SOF_BYTE      (8'hAA),
      .P1_RESET      (24'hFF0000),
      .P2_RESET      (24'h0000FF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data_rx     (data_rx),
      .data_ready  (data_ready),
      .color_p1    (color_p1),
      .color_p2    (color_p2),
      .color_update(color_update),
      .update_sel  (update_sel),
      .frame_err   (frame_err),
      .err_code    (err_code),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the byte
   // was consumed, so outputs of that edge are visible on return.
   task automatic send_byte(input logic [7:0] b);
      data_rx    = b;
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      data_rx    = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] sel, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b,
                             input logic [7:0] chk);
      send_byte(8'hAA);
      send_byte(sel);
      send_byte(r);
      send_byte(g);
      send_byte(b);
      send_byte(chk);
   endtask

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200us;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation time limit exceeded");
   end

   initial begin
      reset      = 1'b1;
      data_rx    = 8'h00;
      data_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state.
      check("rst_p1",  color_p1,     24'hFF0000);
      check("rst_p2",  color_p2,     24'h0000FF);
      check("rst_busy", busy,        1'b0);
      check("rst_upd", color_update, 1'b0);
      check("rst_err", frame_err,    1'b0);
      check("rst_code", err_code,    2'd0);
      check("rst_sel", update_sel,   1'b0);

      // Valid p1 frame: CHK = 01^12^34^56 = 71.
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      check("mid_busy", busy, 1'b1);
      send_byte(8'h71);
      check("f1_p1",   color_p1,     24'h123456);
      check("f1_upd",  color_update, 1'b1);
      check("f1_sel",  update_sel,   1'b0);
      check("f1_p2",   color_p2,     24'h0000FF);
      check("f1_err",  frame_err,    1'b0);
      check("f1_busy", busy,         1'b0);
      @(negedge clk);
      check("f1_upd_pulse", color_update, 1'b0);

      // Valid p2 frame: CHK = 02^00^FF^00 = FD.
      send_frame(8'h02, 8'h00, 8'hFF, 8'h00, 8'hFD);
      check("f2_p2",  color_p2,     24'h00FF00);
      check("f2_sel", update_sel,   1'b1);
      check("f2_upd", color_update, 1'b1);
      check("f2_p1",  color_p1,     24'h123456);

      // Noise without SOF is ignored.
      send_byte(8'h13);
      check("noise1_busy", busy, 1'b0);
      check("noise1_err",  frame_err, 1'b0);
      send_byte(8'h77);
      check("noise2_busy", busy, 1'b0);
      check("noise2_err",  frame_err, 1'b0);

      // Bad checksum on p1 frame.
      send_frame(8'h01, 8'h12, 8'h34, 8'h56, 8'h00);
      check("chk_err",  frame_err,    1'b1);
      check("chk_code", err_code,     2'd2);
      check("chk_upd",  color_update, 1'b0);
      check("chk_p1",   color_p1,     24'h123456);
      @(negedge clk);
      check("chk_err_pulse", frame_err, 1'b0);
      check("chk_code_hold", err_code,  2'd2);

      // Bad checksum on p2 frame with new color data (correct CHK is 02).
      send_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h00);
      check("chk2_err", frame_err, 1'b1);
      check("chk2_p2",  color_p2,  24'h00FF00);

      // Bad select.
      send_byte(8'hAA);
      send_byte(8'h03);
      check("sel_err",  frame_err, 1'b1);
      check("sel_code", err_code,  2'd1);
      check("sel_busy", busy,      1'b0);

      // Timeout: error exactly 20 cycles after the 01 strobe.
      send_byte(8'hAA);
      send_byte(8'h01);
      repeat (19) @(negedge clk);
      check("to_early_err",  frame_err, 1'b0);
      check("to_early_busy", busy,      1'b1);
      @(negedge clk);
      check("to_err",  frame_err, 1'b1);
      check("to_code", err_code,  2'd3);
      check("to_busy", busy,      1'b0);
      // Following valid frame: CHK = 02^0A^0B^0C = 0F.
      send_frame(8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h0F);
      check("to_after_p2",  color_p2,     24'h0A0B0C);
      check("to_after_upd", color_update, 1'b1);

      // Timeout race: R byte lands on the limit cycle. CHK = 01^44^55^66 = 76.
      send_byte(8'hAA);
      send_byte(8'h01);
      repeat (19) @(negedge clk);
      send_byte(8'h44);
      check("race_err",  frame_err, 1'b0);
      check("race_busy", busy,      1'b1);
      send_byte(8'h55);
      send_byte(8'h66);
      send_byte(8'h76);
      check("race_p1",   color_p1,     24'h445566);
      check("race_upd",  color_update, 1'b1);
      check("race_err2", frame_err,    1'b0);
      check("race_code", err_code,     2'd3);

      // Reset after the G byte discards the frame and restores colors.
      send_byte(8'hAA);
      send_byte(8'h02);
      send_byte(8'h77);
      send_byte(8'h88);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrst_p1",   color_p1,  24'hFF0000);
      check("mrst_p2",   color_p2,  24'h0000FF);
      check("mrst_err",  frame_err, 1'b0);
      check("mrst_busy", busy,      1'b0);
      send_byte(8'h99);
      send_byte(8'h64);
      check("mrst_tail_busy", busy,         1'b0);
      check("mrst_tail_upd",  color_update, 1'b0);
      check("mrst_tail_p2",   color_p2,     24'h0000FF);

      // Back-to-back frames, strobes on consecutive cycles.
      // p1 <- 0A0B0C (CHK 0C), p2 <- 010203 (CHK 02).
      send_frame(8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0C);
      check("b2b1_p1",  color_p1,     24'h0A0B0C);
      check("b2b1_upd", color_update, 1'b1);
      check("b2b1_sel", update_sel,   1'b0);
      send_byte(8'hAA);
      check("b2b_gap_upd", color_update, 1'b0);
      send_byte(8'h02);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h02);
      check("b2b2_p2",  color_p2,     24'h010203);
      check("b2b2_upd", color_update, 1'b1);
      check("b2b2_sel", update_sel,   1'b1);
      check("b2b2_err", frame_err,    1'b0);
      check("b2b2_p1",  color_p1,     24'h0A0B0C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
